// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises IF and MEM stage accesses onto one fixed-latency memory port.
// D side has fixed priority; every access ends in a DONE cycle that returns to IDLE.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CW = $clog2(MEM_LAT + 1);

    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D} state_t;

    state_t            r_state, w_next;
    logic [CW-1:0]     r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we, r_kill;
    logic              w_grant_d, w_grant_i, w_busy, w_last;

    assign w_grant_d = (r_state == IDLE) && d_req;
    assign w_grant_i = (r_state == IDLE) && !d_req && if_req && !if_flush;
    assign w_busy    = (r_state == BUSY_I) || (r_state == BUSY_D);
    assign w_last    = w_busy && (r_cnt == '0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = d_req ? BUSY_D : (if_req && !if_flush) ? BUSY_I : IDLE;
            BUSY_I:  w_next = (r_cnt == '0) ? DONE_I : BUSY_I;
            BUSY_D:  w_next = (r_cnt == '0) ? DONE_D : BUSY_D;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_we     <= 1'b0;
            r_kill   <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant_d) begin
                r_cnt   <= CW'(MEM_LAT - 1);
                r_addr  <= d_addr;
                r_we    <= d_we;
                r_wdata <= d_wdata;
            end else if (w_grant_i) begin
                r_cnt  <= CW'(MEM_LAT - 1);
                r_addr <= if_addr;
                r_we   <= 1'b0;
            end else if (w_busy && r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end
            // A redirect can't abort the memory access, so remember it until DONE_I.
            if (r_state == BUSY_I && if_flush)
                r_kill <= 1'b1;
            else if (r_state == DONE_I)
                r_kill <= 1'b0;
            if (w_last && r_state == BUSY_I && !r_kill && !if_flush)
                if_rdata <= mem_rdata;
            if (w_last && r_state == BUSY_D && !r_we)
                d_rdata <= mem_rdata;
        end
    end

    assign mem_valid = w_busy;
    assign mem_we    = (r_state == BUSY_D) && r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign d_ready   = (r_state == DONE_D);
    assign if_ready  = (r_state == DONE_I) && !r_kill && !if_flush;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors for the arbiter at MEM_LAT=4, plus MEM_LAT=1 streaming.
// A combinational memory model returns a word derived from the address.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0, if_flush = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic        if_ready, d_ready, mem_valid, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        if_req1 = 1'b0;
    logic [31:0] if_addr1 = '0;
    logic        if_ready1, d_ready1, mem_valid1, mem_we1;
    logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a == 32'h10 ? 32'h0050_0093 : a == 32'h200 ? 32'hDEAD_BEEF : {16'hC0DE, a[15:0]};
    endfunction

    assign mem_rdata  = memf(mem_addr);
    assign mem_rdata1 = memf(mem_addr1);

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4)) u4 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u1 (
        .clk(clk), .reset(reset),
        .if_req(if_req1), .if_addr(if_addr1), .if_flush(1'b0), .if_ready(if_ready1), .if_rdata(if_rdata1),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0), .d_ready(d_ready1), .d_rdata(d_rdata1),
        .mem_valid(mem_valid1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
    );

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        int          flush_edge;
        int          exp_ie;
        int          exp_de;
        logic [31:0] exp_ir;
        logic [31:0] exp_dr;
        int          exp_wc;
        int          exp_vc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Edges are numbered from 1 = the first edge that sees the new request.
    task automatic run_vec(input int idx, input vec_t v);
        int ie = 0, de = 0, ip = 0, dp = 0, wc = 0, vc = 0;
        if_req   = v.if_req;
        if_addr  = v.if_addr;
        d_req    = v.d_req;
        d_we     = v.d_we;
        d_addr   = v.d_addr;
        d_wdata  = v.d_wdata;
        if_flush = (v.flush_edge == 0);
        for (int e = 1; e <= 14; e++) begin
            @(posedge clk); #1;
            if (mem_valid) vc++;
            if (mem_we && mem_addr == v.d_addr && mem_wdata == v.d_wdata) wc++;
            if (if_ready) begin ip++; if (ie == 0) ie = e; if_req = 1'b0; end
            if (d_ready) begin dp++; if (de == 0) de = e; d_req = 1'b0; end
            if (e == v.flush_edge) begin if_flush = 1'b1; if_req = 1'b0; end
            else if_flush = 1'b0;
        end
        chk($sformatf("v%0d if_ready edge", idx), ie, v.exp_ie);
        chk($sformatf("v%0d d_ready edge", idx), de, v.exp_de);
        chk($sformatf("v%0d if_ready pulses", idx), ip, (v.exp_ie != 0) ? 1 : 0);
        chk($sformatf("v%0d d_ready pulses", idx), dp, (v.exp_de != 0) ? 1 : 0);
        chk($sformatf("v%0d if_rdata", idx), if_rdata, v.exp_ir);
        chk($sformatf("v%0d d_rdata", idx), d_rdata, v.exp_dr);
        chk($sformatf("v%0d mem_we cycles", idx), wc, v.exp_wc);
        chk($sformatf("v%0d mem_valid cycles", idx), vc, v.exp_vc);
    endtask

    initial begin
        vec_t vecs[7];
        int rd_edge[3];
        logic [31:0] rd_val[3];
        int np, nv, bad;
        vecs[0] = '{1, 32'h10, 0, 0, 32'h0,   32'h0,        99, 5,  0, 32'h0050_0093, 32'h0,         0, 4};
        vecs[1] = '{1, 32'h14, 1, 0, 32'h200, 32'h0,        99, 11, 5, 32'hC0DE_0014, 32'hDEAD_BEEF, 0, 8};
        vecs[2] = '{0, 32'h0,  1, 1, 32'h40,  32'h1234_5678, 99, 0,  5, 32'hC0DE_0014, 32'hDEAD_BEEF, 4, 4};
        vecs[3] = '{1, 32'h20, 0, 0, 32'h0,   32'h0,        2,  0,  0, 32'hC0DE_0014, 32'hDEAD_BEEF, 0, 4};
        vecs[4] = '{1, 32'h24, 0, 0, 32'h0,   32'h0,        99, 5,  0, 32'hC0DE_0024, 32'hDEAD_BEEF, 0, 4};
        vecs[5] = '{0, 32'h0,  1, 0, 32'h80,  32'h0,        99, 0,  5, 32'hC0DE_0024, 32'hC0DE_0080, 0, 4};
        vecs[6] = '{1, 32'h30, 0, 0, 32'h0,   32'h0,        0,  6,  0, 32'hC0DE_0030, 32'hC0DE_0080, 0, 4};

        repeat (2) @(posedge clk);
        #1;
        chk("reset if_ready", if_ready, 0);
        chk("reset d_ready", d_ready, 0);
        chk("reset mem_valid", mem_valid, 0);
        chk("reset mem_we", mem_we, 0);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset mem_wdata", mem_wdata, 0);
        chk("reset if_rdata", if_rdata, 0);
        chk("reset d_rdata", d_rdata, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Reset in the middle of a store must drop the port without a clock edge.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234_5678;
        repeat (2) @(posedge clk);
        #1;
        chk("mid BUSY_D mem_valid", mem_valid, 1);
        chk("mid BUSY_D mem_we", mem_we, 1);
        #2 reset = 1'b0;
        #1;
        chk("async rst mem_valid", mem_valid, 0);
        chk("async rst mem_we", mem_we, 0);
        chk("async rst d_ready", d_ready, 0);
        chk("async rst mem_addr", mem_addr, 0);
        d_req = 1'b0; d_we = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        np = 0; nv = 0;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk); #1;
            if (d_ready) np++;
            if (mem_valid) nv++;
        end
        chk("post rst stale d_ready", np, 0);
        chk("post rst mem_valid", nv, 0);

        // MEM_LAT=1 with a continuously held fetch request.
        np = 0; nv = 0; bad = 0;
        if_addr1 = 32'h0; if_req1 = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk); #1;
            if (mem_valid1) nv++;
            if (mem_we1) bad++;
            if (if_ready1) begin
                if (np < 3) begin rd_edge[np] = e; rd_val[np] = if_rdata1; end
                np++;
                if_addr1 = if_addr1 + 32'h4;
            end
        end
        if_req1 = 1'b0;
        chk("lat1 ready pulses", np, 3);
        chk("lat1 busy cycles", nv, 3);
        chk("lat1 mem_we", bad, 0);
        for (int k = 0; k < 3 && k < np; k++) begin
            chk($sformatf("lat1 ready%0d edge", k), rd_edge[k], 2 + 3 * k);
            chk($sformatf("lat1 ready%0d rdata", k), rd_val[k], memf(32'(4 * k)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
